// File: rtl/quadrature_decoder_if.sv
// ============================================================================
// Module      : quadrature_decoder_if
// Description : Control/status bundle of the quadrature decoder. The consumer
//               (master) drives clear/load and reads back position, step
//               pulses and the sticky error flag; the decoder is the slave.
// Signals     : clear      - sync clear of position, accumulator and error
//               load       - sync load of position from load_value
//               load_value - CNT_WIDTH value used by load
//               position   - unsigned position count
//               step_valid - one-cycle pulse per detent step
//               step_dir   - 1 = forward (A leads B), valid with step_valid
//               error      - sticky illegal-transition flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface quadrature_decoder_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 clear;
  logic                 load;
  logic [CNT_WIDTH-1:0] load_value;
  logic [CNT_WIDTH-1:0] position;
  logic                 step_valid;
  logic                 step_dir;
  logic                 error;

  modport master (
    output clear, load, load_value,
    input  position, step_valid, step_dir, error
  );

  modport slave (
    input  clear, load, load_value,
    output position, step_valid, step_dir, error
  );
endinterface

`default_nettype wire

// File: rtl/quadrature_decoder.sv
// ============================================================================
// Module      : quadrature_decoder
// Description : Quadrature decoder for rotary encoders. Synchronises the A/B
//               channels, decodes Gray-code transitions into sub-steps, groups
//               STEPS_PER_DETENT sub-steps into one detent step and maintains a
//               saturating or wrapping position counter. Provides clear/load
//               and a sticky illegal-transition error.
// Ports       : clk      - system clock (posedge)
//               rst_n    - asynchronous active-low reset
//               enc_ch_a - encoder channel A (asynchronous)
//               enc_ch_b - encoder channel B (asynchronous)
//               bus      - quadrature_decoder_if.slave control/status bundle
// Config      : QDEC_GLITCH_FILTER_EN - when defined, inserts a per-channel
//               glitch filter of FILTER_LEN cycles after the synchroniser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module quadrature_decoder #(
  parameter int CNT_WIDTH        = 8,
  parameter int STEPS_PER_DETENT = 4,
  parameter int SYNC_STAGES      = 2,
  parameter int FILTER_LEN       = 4,
  parameter int SATURATE         = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enc_ch_a,
  input  logic                 enc_ch_b,
  quadrature_decoder_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Accumulator must hold +/-STEPS_PER_DETENT transiently (max 4) -> 4 bits.
  localparam int ACC_W = 4;
  localparam logic signed [ACC_W-1:0] ACC_ONE  = 4'sd1;
  localparam logic signed [ACC_W-1:0] ACC_POS  = ACC_W'(STEPS_PER_DETENT);
  localparam logic signed [ACC_W-1:0] ACC_NEG  = -ACC_POS;
  localparam logic [CNT_WIDTH-1:0]    POS_MAX  = '1;

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int FILTER_CYCLES = FILTER_LEN;
`else
  // Filter absent: it contributes no start-up fill cycles.
  localparam int FILTER_CYCLES = (FILTER_LEN > 0) ? 0 : 0;
`endif

  localparam int FILL_CYCLES = SYNC_STAGES + FILTER_CYCLES;
  localparam int FILL_W      = $clog2(FILL_CYCLES + 1);

  // --------------------------------------------------------------------------
  // Synchroniser
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_a_q;
  logic [SYNC_STAGES-1:0] sync_b_q;
  logic [1:0]             synced_ab;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], enc_ch_a};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], enc_ch_b};
    end
  end

  // Bit 1 = A, bit 0 = B, so the forward order reads 00->10->11->01.
  assign synced_ab = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

  // --------------------------------------------------------------------------
  // Optional glitch filter
  // --------------------------------------------------------------------------
  logic [1:0] cur_ab;

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN) + 1;

  for (genvar ch = 0; ch < 2; ch++) begin : g_filter_ch
    logic           level_q;
    logic [FCW-1:0] cnt_q;

    // The filtered level follows the synced input only after the new level
    // has been present for FILTER_LEN consecutive cycles; any return to the
    // current filtered level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level_q <= 1'b0;
        cnt_q   <= '0;
      end else if (synced_ab[ch] == level_q) begin
        cnt_q   <= '0;
      end else if (cnt_q == FCW'(FILTER_LEN - 1)) begin
        level_q <= synced_ab[ch];
        cnt_q   <= '0;
      end else begin
        cnt_q   <= cnt_q + 1'b1;
      end
    end

    assign cur_ab[ch] = level_q;
  end : g_filter_ch
`else
  assign cur_ab = synced_ab;
`endif

  // --------------------------------------------------------------------------
  // Start-up FSM: wait for the input pipeline to fill, capture the settled
  // level as the reference, then decode. Prevents a spurious error or count
  // when the encoder rests at a non-zero level at reset release.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic                arm;
  logic                run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    arm        = 1'b0;
    run        = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (fill_cnt_q == FILL_W'(FILL_CYCLES - 1)) begin
          state_d    = ST_ARM;
          fill_cnt_d = '0;
        end else begin
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end
      ST_ARM: begin
        arm     = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        run     = 1'b1;
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Transition decode
  // --------------------------------------------------------------------------
  function automatic logic [1:0] gray_next(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      2'b00:   nxt = 2'b10;
      2'b10:   nxt = 2'b11;
      2'b11:   nxt = 2'b01;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  logic [1:0] prev_ab_q, prev_ab_d;
  logic       is_fwd;
  logic       is_rev;
  logic       is_illegal;

  assign is_fwd     = run && (cur_ab == gray_next(prev_ab_q));
  assign is_rev     = run && (prev_ab_q == gray_next(cur_ab));
  assign is_illegal = run && (cur_ab == ~prev_ab_q);

  // --------------------------------------------------------------------------
  // Accumulator, position, flags
  // --------------------------------------------------------------------------
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_inc;
  logic [CNT_WIDTH-1:0]    pos_q, pos_d, pos_step;
  logic                    step_fwd;
  logic                    step_rev;
  logic                    step_valid_q, step_valid_d;
  logic                    step_dir_q, step_dir_d;
  logic                    error_q, error_d;

  always_comb begin
    acc_inc = acc_q;
    if (is_fwd) begin
      acc_inc = acc_q + ACC_ONE;
    end else if (is_rev) begin
      acc_inc = acc_q - ACC_ONE;
    end

    step_fwd = (acc_inc == ACC_POS);
    step_rev = (acc_inc == ACC_NEG);

    // Saturation holds the count at the rails; wrap relies on modulo
    // arithmetic of the CNT_WIDTH-bit adder.
    pos_step = pos_q;
    if (step_fwd) begin
      if ((SATURATE != 0) && (pos_q == POS_MAX)) begin
        pos_step = pos_q;
      end else begin
        pos_step = pos_q + 1'b1;
      end
    end else if (step_rev) begin
      if ((SATURATE != 0) && (pos_q == '0)) begin
        pos_step = pos_q;
      end else begin
        pos_step = pos_q - 1'b1;
      end
    end

    // clear > load > step; the step pulse itself is never suppressed.
    if (bus.clear) begin
      pos_d = '0;
    end else if (bus.load) begin
      pos_d = bus.load_value;
    end else begin
      pos_d = pos_step;
    end

    if (bus.clear || bus.load || step_fwd || step_rev) begin
      acc_d = '0;
    end else begin
      acc_d = acc_inc;
    end

    if (bus.clear) begin
      error_d = 1'b0;
    end else if (is_illegal) begin
      error_d = 1'b1;
    end else begin
      error_d = error_q;
    end

    prev_ab_d    = (arm || run) ? cur_ab : prev_ab_q;
    step_valid_d = step_fwd || step_rev;
    step_dir_d   = (step_fwd || step_rev) ? step_fwd : step_dir_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ab_q    <= 2'b00;
      acc_q        <= '0;
      pos_q        <= '0;
      step_valid_q <= 1'b0;
      step_dir_q   <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      prev_ab_q    <= prev_ab_d;
      acc_q        <= acc_d;
      pos_q        <= pos_d;
      step_valid_q <= step_valid_d;
      step_dir_q   <= step_dir_d;
      error_q      <= error_d;
    end
  end

  assign bus.position   = pos_q;
  assign bus.step_valid = step_valid_q;
  assign bus.step_dir   = step_dir_q;
  assign bus.error      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_quadrature_decoder.sv
// ============================================================================
// Module      : tb_quadrature_decoder
// Description : Self-checking bench for quadrature_decoder. Two instances are
//               driven from the same encoder pins: one saturating, one
//               wrapping. A behavioural model pushes expected detent steps to
//               a queue as stimulus is applied; a monitor pops and compares
//               them whenever the DUT pulses step_valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_quadrature_decoder;

  localparam int S = 4;
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic enc_a;
  logic enc_b;

  always #5 clk = ~clk;

  quadrature_decoder_if #(.CNT_WIDTH(8)) bus_s ();
  quadrature_decoder_if #(.CNT_WIDTH(8)) bus_w ();

  quadrature_decoder #(
    .CNT_WIDTH(8), .STEPS_PER_DETENT(S), .SYNC_STAGES(2), .FILTER_LEN(4), .SATURATE(1)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .enc_ch_a(enc_a), .enc_ch_b(enc_b), .bus(bus_s)
  );

  quadrature_decoder #(
    .CNT_WIDTH(8), .STEPS_PER_DETENT(S), .SYNC_STAGES(2), .FILTER_LEN(4), .SATURATE(0)
  ) dut_wrap (
    .clk(clk), .rst_n(rst_n), .enc_ch_a(enc_a), .enc_ch_b(enc_b), .bus(bus_w)
  );

  // --------------------------------------------------------------------------
  // Scoreboard and model state
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic       dir;
    logic [7:0] ps;
    logic [7:0] pw;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_steps_seen = 0;

  logic [1:0] m_prev;
  int         m_acc;
  logic [7:0] m_ps;
  logic [7:0] m_pw;
  logic       m_load_pending;
  logic [7:0] m_load_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Forward successor in the Gray sequence, keyed {A,B}.
  function automatic logic [1:0] fwd_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_step(input logic dir);
    exp_t e;
    if (m_load_pending) begin
      m_ps = m_load_val;
      m_pw = m_load_val;
      m_load_pending = 1'b0;
    end else if (dir) begin
      m_ps = (m_ps == 8'hFF) ? 8'hFF : m_ps + 8'd1;
      m_pw = m_pw + 8'd1;
    end else begin
      m_ps = (m_ps == 8'h00) ? 8'h00 : m_ps - 8'd1;
      m_pw = m_pw - 8'd1;
    end
    e.dir = dir;
    e.ps  = m_ps;
    e.pw  = m_pw;
    exp_q.push_back(e);
  endtask

  task automatic drive_ab(input logic [1:0] ab, input int hold);
    enc_a = ab[1];
    enc_b = ab[0];
    if (ab != m_prev) begin
      if (ab == ~m_prev) begin
        // illegal: error only, accumulator untouched
      end else if (ab == fwd_of(m_prev)) begin
        m_acc++;
      end else begin
        m_acc--;
      end
      if (m_acc == S) begin
        m_acc = 0;
        model_step(1'b1);
      end else if (m_acc == -S) begin
        m_acc = 0;
        model_step(1'b0);
      end
    end
    m_prev = ab;
    repeat (hold) tick();
  endtask

  task automatic do_clear();
    bus_s.clear = 1'b1;
    bus_w.clear = 1'b1;
    tick();
    bus_s.clear = 1'b0;
    bus_w.clear = 1'b0;
    m_ps = 8'h00;
    m_pw = 8'h00;
    m_acc = 0;
  endtask

  task automatic do_load(input logic [7:0] v);
    bus_s.load = 1'b1;       bus_w.load = 1'b1;
    bus_s.load_value = v;    bus_w.load_value = v;
    tick();
    bus_s.load = 1'b0;       bus_w.load = 1'b0;
    m_ps = v;
    m_pw = v;
    m_acc = 0;
  endtask

  task automatic check_state(input string tag, input logic err_exp);
    check({tag, "_pos_sat"},  {24'd0, bus_s.position}, {24'd0, m_ps});
    check({tag, "_pos_wrap"}, {24'd0, bus_w.position}, {24'd0, m_pw});
    check({tag, "_err_sat"},  {31'd0, bus_s.error},    {31'd0, err_exp});
    check({tag, "_err_wrap"}, {31'd0, bus_w.error},    {31'd0, err_exp});
  endtask

  task automatic check_drained(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_pending_steps"}, exp_q.size(), 0);
  endtask

  task automatic measure_latency(input string tag);
    int lat = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus_s.step_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    check(tag, lat, LAT);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: pop the scoreboard whenever a step pulse appears
  // --------------------------------------------------------------------------
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && (bus_s.step_valid === 1'b1 || bus_w.step_valid === 1'b1)) begin
      exp_t e;
      n_steps_seen++;
      check("step_valid_sat_vs_wrap", {31'd0, bus_w.step_valid}, {31'd0, bus_s.step_valid});
      if (exp_q.size() == 0) begin
        check("step_valid_unexpected", {31'd0, bus_s.step_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("step_dir_sat",  {31'd0, bus_s.step_dir}, {31'd0, e.dir});
        check("step_dir_wrap", {31'd0, bus_w.step_dir}, {31'd0, e.dir});
        check("step_pos_sat",  {24'd0, bus_s.position}, {24'd0, e.ps});
        check("step_pos_wrap", {24'd0, bus_w.position}, {24'd0, e.pw});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    enc_a = 1'b1;
    enc_b = 1'b1;
    bus_s.clear = 1'b0;  bus_w.clear = 1'b0;
    bus_s.load  = 1'b0;  bus_w.load  = 1'b0;
    bus_s.load_value = 8'h00;  bus_w.load_value = 8'h00;
    m_prev = 2'b11;
    m_acc  = 0;
    m_ps   = 8'h00;
    m_pw   = 8'h00;
    m_load_pending = 1'b0;
    m_load_val     = 8'h00;

    // Reset values
    repeat (3) tick();
    check_state("reset", 1'b0);
    check("reset_step_valid", {31'd0, bus_s.step_valid}, 32'd0);
    check("reset_step_dir",   {31'd0, bus_s.step_dir},   32'd0);

    // Start-up with A=B=1: no error, no motion
    rst_n = 1'b1;
    repeat (20) tick();
    check_state("startup", 1'b0);
    check("startup_no_steps", n_steps_seen, 0);

    // Walk to 00, clear the partial accumulation, then one forward detent
    drive_ab(2'b01, 8);
    drive_ab(2'b00, 8);
    do_clear();
    drive_ab(2'b10, 8);
    drive_ab(2'b11, 8);
    drive_ab(2'b01, 8);
    drive_ab(2'b00, 0);
    measure_latency("fwd_step_latency");
    repeat (8) tick();
    check_drained("fwd_detent");
    check_state("fwd_detent", 1'b0);

    // Reverse detents: 1 -> 0, then saturate at 0 / wrap to 255
    for (int k = 0; k < 2; k++) begin
      drive_ab(2'b01, 8);
      drive_ab(2'b11, 8);
      drive_ab(2'b10, 8);
      drive_ab(2'b00, 8);
    end
    check_drained("rev_detents");
    check_state("rev_detents", 1'b0);

    // Forward from the rails: sat 0->1, wrap 255->0
    drive_ab(2'b10, 8);
    drive_ab(2'b11, 8);
    drive_ab(2'b01, 8);
    drive_ab(2'b00, 8);
    check_drained("fwd_from_rail");
    check_state("fwd_from_rail", 1'b0);

    // Top rail: load 0xFF then forward -> sat holds 255, wrap -> 0
    do_load(8'hFF);
    check_state("load_ff", 1'b0);
    drive_ab(2'b10, 8);
    drive_ab(2'b11, 8);
    drive_ab(2'b01, 8);
    drive_ab(2'b00, 8);
    check_drained("top_rail");
    check_state("top_rail", 1'b0);

    // Illegal transitions: sticky error, position unchanged, cleared by clear
    drive_ab(2'b11, 8);
    check_state("illegal1", 1'b1);
    drive_ab(2'b00, 8);
    check_state("illegal2", 1'b1);
    do_clear();
    tick();
    check_state("after_clear", 1'b0);

    // Two forward then two reverse sub-steps: no detent
    drive_ab(2'b10, 8);
    drive_ab(2'b11, 8);
    drive_ab(2'b10, 8);
    drive_ab(2'b00, 8);
    check("partial_no_steps", exp_q.size(), 0);
    check_state("partial", 1'b0);

    // Load coincident with a step pulse: step still pulses, position = load
    drive_ab(2'b10, 8);
    drive_ab(2'b11, 8);
    drive_ab(2'b01, 8);
    m_load_pending = 1'b1;
    m_load_val     = 8'h80;
    drive_ab(2'b00, 0);
    tick();
    tick();
    bus_s.load = 1'b1;         bus_w.load = 1'b1;
    bus_s.load_value = 8'h80;  bus_w.load_value = 8'h80;
    tick();
    bus_s.load = 1'b0;         bus_w.load = 1'b0;
    repeat (4) tick();
    check_drained("load_with_step");
    check_state("load_with_step", 1'b0);

    // Reset mid-rotation with error set
    drive_ab(2'b10, 8);
    drive_ab(2'b01, 8);
    check_state("pre_reset", 1'b1);
    rst_n = 1'b0;
    #1;
    m_ps = 8'h00;
    m_pw = 8'h00;
    m_acc = 0;
    check_state("async_reset", 1'b0);
    check("async_reset_step_valid", {31'd0, bus_s.step_valid}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check_state("post_reset", 1'b0);

`ifdef QDEC_GLITCH_FILTER_EN
    // Glitch filter: short pulses on both channels / on A must vanish
    drive_ab(2'b00, 8);
    do_clear();
    repeat (4) tick();
    enc_a = 1'b1;
    enc_b = 1'b1;
    repeat (2) tick();
    enc_a = 1'b0;
    enc_b = 1'b0;
    repeat (12) tick();
    check_state("glitch_both", 1'b0);
    enc_a = 1'b1;
    repeat (2) tick();
    enc_a = 1'b0;
    repeat (12) tick();
    drive_ab(2'b10, 12);
    drive_ab(2'b11, 12);
    drive_ab(2'b01, 12);
    drive_ab(2'b00, 0);
    measure_latency("filter_step_latency");
    repeat (12) tick();
    check_drained("filter");
    check_state("filter", 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
